// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter_pkg: shared CDB packet types and sizing constants for the completion arbiter
package cdb_arbiter_pkg;
  localparam int CDB_N = 2;
  localparam int NUM_FU_DEF = 5;
  localparam int B_MASK_BITS = 4;
  localparam int PHYS_REG_BITS = 6;
  localparam int ROB_IDX_BITS = 5;
  localparam int NUM_SCALAR_BITS = $clog2(CDB_N + 1);
  typedef logic [B_MASK_BITS-1:0] b_mask_t;
  typedef logic [PHYS_REG_BITS-1:0] phys_reg_idx_t;
  typedef struct packed {
    logic valid;
    phys_reg_idx_t complete_tag;
    logic [ROB_IDX_BITS-1:0] rob_idx;
    b_mask_t b_mask;
    logic [31:0] result;
  } cdb_etb_packet_t;
  function automatic logic killed(b_mask_t m, logic sq_valid, b_mask_t sq_mask);
    return sq_valid && |(m & sq_mask);
  endfunction
endpackage

// File: rtl/cdb_arbiter_rr_select.sv
// rr_select: rotating priority selector handing out up to N one-hot grants starting at ptr
module rr_select #(
  parameter int N = 2,
  parameter int NUM_FU = 5,
  parameter int IDX_BITS = $clog2(NUM_FU)
) (
  input  logic [NUM_FU-1:0]        req,
  input  logic [IDX_BITS-1:0]      ptr,
  output logic [N-1:0][NUM_FU-1:0] gnt,
  output logic [IDX_BITS-1:0]      last,
  output logic                     any
);
  int pos [NUM_FU];
  int rank [NUM_FU];
  int best;
  // each requester's slot is the number of requesters ahead of it in scan order
  always_comb begin
    gnt = '0;
    last = ptr;
    any = 1'b0;
    best = -1;
    for (int i = 0; i < NUM_FU; i++)
      pos[i] = (i >= int'(ptr)) ? i - int'(ptr) : i + NUM_FU - int'(ptr);
    for (int i = 0; i < NUM_FU; i++) begin
      rank[i] = 0;
      for (int j = 0; j < NUM_FU; j++)
        if (req[j] && pos[j] < pos[i]) rank[i]++;
    end
    for (int i = 0; i < NUM_FU; i++)
      for (int s = 0; s < N; s++)
        if (req[i] && rank[i] == s) begin
          gnt[s][i] = 1'b1;
          any = 1'b1;
          if (pos[i] > best) begin
            best = pos[i];
            last = IDX_BITS'(i);
          end
        end
  end
endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin CDB slot arbiter with squash kill and registered broadcast
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int N = CDB_N,
  parameter int NUM_FU = NUM_FU_DEF,
  parameter int FU_IDX_BITS = $clog2(NUM_FU)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_FU-1:0]          fu_req,
  input  cdb_etb_packet_t            fu_packet [NUM_FU],
  input  logic                       squash_valid,
  input  b_mask_t                    squash_b_mask,
  output logic [NUM_FU-1:0]          fu_grant,
  output cdb_etb_packet_t            cdb_completing [N],
  output logic [NUM_SCALAR_BITS-1:0] num_completing
);
  logic [NUM_FU-1:0] kill, live, live_gnt;
  logic [N-1:0][NUM_FU-1:0] slot_gnt;
  logic [FU_IDX_BITS-1:0] rr_ptr, last;
  logic any;
  cdb_etb_packet_t nxt [N];
  logic [NUM_SCALAR_BITS-1:0] nxt_num;
  always_comb begin
    kill = '0;
    for (int i = 0; i < NUM_FU; i++)
      kill[i] = fu_req[i] && killed(fu_packet[i].b_mask, squash_valid, squash_b_mask);
  end
  assign live = fu_req & ~kill;
  rr_select #(.N(N), .NUM_FU(NUM_FU), .IDX_BITS(FU_IDX_BITS)) u_sel (
    .req(live),
    .ptr(rr_ptr),
    .gnt(slot_gnt),
    .last(last),
    .any(any)
  );
  // outgoing masks drop the resolving branch so consumers see the corrected mask
  always_comb begin
    live_gnt = '0;
    nxt_num = '0;
    for (int s = 0; s < N; s++) begin
      live_gnt = live_gnt | slot_gnt[s];
      nxt[s] = '0;
      for (int i = 0; i < NUM_FU; i++)
        if (slot_gnt[s][i]) nxt[s] = fu_packet[i];
      nxt[s].valid = |slot_gnt[s];
      if (squash_valid) nxt[s].b_mask = nxt[s].b_mask & ~squash_b_mask;
      nxt_num = nxt_num + NUM_SCALAR_BITS'(nxt[s].valid);
    end
  end
  assign fu_grant = reset ? '0 : (kill | live_gnt);
  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr <= '0;
      num_completing <= '0;
      cdb_completing <= '{default: '0};
    end else begin
      cdb_completing <= nxt;
      num_completing <= nxt_num;
      if (any) rr_ptr <= (int'(last) == NUM_FU - 1) ? '0 : last + 1'b1;
    end
  end
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed scenarios plus randomized traffic against a scan-order reference model
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;
  localparam int NF = NUM_FU_DEF;
  localparam int NC = CDB_N;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  logic [NF-1:0] fu_req, fu_grant, exp_grant, got_grant;
  cdb_etb_packet_t fu_packet [NF];
  logic squash_valid;
  b_mask_t squash_b_mask;
  cdb_etb_packet_t cdb_completing [NC];
  cdb_etb_packet_t exp_slot [NC];
  logic [NUM_SCALAR_BITS-1:0] num_completing;
  int total = 0, bad = 0;
  int ptr = 0, nxt_ptr = 0, exp_num = 0;
  int age [NF];
  int max_age;
  cdb_arbiter dut (
    .clock(clk),
    .reset(rst),
    .fu_req(fu_req),
    .fu_packet(fu_packet),
    .squash_valid(squash_valid),
    .squash_b_mask(squash_b_mask),
    .fu_grant(fu_grant),
    .cdb_completing(cdb_completing),
    .num_completing(num_completing)
  );
  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  // reference: kills are granted outright; live requests taken in scan order from ptr
  task automatic predict();
    int cnt = 0;
    int last_i = 0;
    exp_grant = '0;
    for (int s = 0; s < NC; s++) exp_slot[s] = '0;
    exp_num = 0;
    nxt_ptr = 0;
    if (rst) return;
    for (int i = 0; i < NF; i++)
      if (fu_req[i] && squash_valid && (fu_packet[i].b_mask & squash_b_mask) != 0) exp_grant[i] = 1'b1;
    for (int k = 0; k < NF; k++) begin
      int i = (ptr + k) % NF;
      if (fu_req[i] && !exp_grant[i] && cnt < NC) begin
        exp_grant[i] = 1'b1;
        exp_slot[cnt] = fu_packet[i];
        exp_slot[cnt].valid = 1'b1;
        if (squash_valid) exp_slot[cnt].b_mask = fu_packet[i].b_mask & ~squash_b_mask;
        cnt++;
        last_i = i;
      end
    end
    exp_num = cnt;
    nxt_ptr = (cnt > 0) ? (last_i + 1) % NF : ptr;
  endtask
  task automatic tick(string tag);
    #1;
    predict();
    got_grant = fu_grant;
    check({tag, "_grant"}, 64'(fu_grant), 64'(exp_grant));
    @(posedge clk);
    #1;
    check({tag, "_num"}, 64'(num_completing), 64'(exp_num));
    for (int s = 0; s < NC; s++)
      check({tag, "_slot"}, exp_slot[s].valid ? 64'(cdb_completing[s]) : 64'(cdb_completing[s].valid), 64'(exp_slot[s]));
    ptr = nxt_ptr;
  endtask
  function automatic cdb_etb_packet_t rand_pkt();
    cdb_etb_packet_t p;
    p.valid = 1'($urandom);
    p.complete_tag = PHYS_REG_BITS'($urandom);
    p.rob_idx = ROB_IDX_BITS'($urandom);
    p.b_mask = B_MASK_BITS'($urandom & $urandom);
    p.result = $urandom;
    return p;
  endfunction
  task automatic set_req(logic [NF-1:0] r);
    fu_req = r;
    for (int i = 0; i < NF; i++)
      fu_packet[i] = '{valid: 1'b1, complete_tag: PHYS_REG_BITS'(i + 1), rob_idx: ROB_IDX_BITS'(i), b_mask: '0, result: 32'(32'hA0 + i)};
    squash_valid = 1'b0;
    squash_b_mask = '0;
  endtask
  // granted or idle FUs may present new work; ungranted ones hold steady
  task automatic fu_update(bit keep_all, bit sq_en);
    for (int i = 0; i < NF; i++)
      if (exp_grant[i] || !fu_req[i]) begin
        fu_req[i] = keep_all || ($urandom_range(0, 2) != 0);
        fu_packet[i] = rand_pkt();
      end
    squash_valid = sq_en && ($urandom_range(0, 3) == 0);
    squash_b_mask = B_MASK_BITS'(1 << $urandom_range(0, B_MASK_BITS - 1));
  endtask
  initial begin
    rst = 1'b1;
    set_req('1);
    repeat (3) tick("rst");
    rst = 1'b0;
    tick("t1");
    check("t1_grant_const", 64'(got_grant), 64'(5'b00011));
    check("t1_tag0", 64'(cdb_completing[0].complete_tag), 64'd1);
    check("t1_tag1", 64'(cdb_completing[1].complete_tag), 64'd2);
    fu_req = fu_req & ~exp_grant;
    tick("t2a");
    check("t2a_grant_const", 64'(got_grant), 64'(5'b01100));
    fu_req = fu_req & ~exp_grant;
    tick("t2b");
    check("t2b_grant_const", 64'(got_grant), 64'(5'b10000));
    set_req('0);
    tick("idle");
    check("idle_num", 64'(num_completing), 64'd0);
    set_req(5'b01111);
    tick("pre3a");
    fu_req = fu_req & ~exp_grant;
    tick("pre3b");
    set_req(5'b10001);
    tick("t3");
    check("t3_grant_const", 64'(got_grant), 64'(5'b10001));
    check("t3_slot0_fu4", 64'(cdb_completing[0].complete_tag), 64'd5);
    check("t3_slot1_fu0", 64'(cdb_completing[1].complete_tag), 64'd1);
    set_req(5'b00111);
    fu_packet[1].b_mask = 4'b0100;
    squash_valid = 1'b1;
    squash_b_mask = 4'b0100;
    tick("t4");
    check("t4_grant_const", 64'(got_grant), 64'(5'b00111));
    check("t4_num", 64'(num_completing), 64'd2);
    check("t4_slot0_fu2", 64'(cdb_completing[0].complete_tag), 64'd3);
    check("t4_slot1_fu0", 64'(cdb_completing[1].complete_tag), 64'd1);
    set_req(5'b01000);
    fu_packet[3].b_mask = 4'b0011;
    squash_valid = 1'b1;
    squash_b_mask = 4'b0001;
    tick("t5");
    check("t5_grant_const", 64'(got_grant), 64'(5'b01000));
    check("t5_num", 64'(num_completing), 64'd0);
    set_req('1);
    tick("t5b");
    check("t5b_ptr_kept", 64'(got_grant), 64'(5'b00110));
    for (int i = 0; i < NF; i++) age[i] = 0;
    repeat (20) begin
      fu_update(1'b1, 1'b0);
      tick("t6");
      max_age = 0;
      for (int i = 0; i < NF; i++) begin
        age[i] = got_grant[i] ? 0 : age[i] + 1;
        if (age[i] > max_age) max_age = age[i];
      end
      check("t6_fair", 64'(max_age <= 2), 64'd1);
    end
    repeat (400) begin
      rst = ($urandom_range(0, 49) == 0);
      fu_update(1'b0, 1'b1);
      tick("rnd");
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
